uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: clk cycles per serial bit; legal values are even integers of 4 or more.
REQ-002 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 Port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-004 Port rx, input, 1: asynchronous serial line; idle high; 8N1 framing, LSB first.
REQ-005 Port data_out, output, 8: last correctly framed byte; holds its value between frames.
REQ-006 Port valid, output, 1: one-cycle pulse when data_out has been updated.
REQ-007 Port frame_err, output, 1: one-cycle pulse when the stop bit is sampled low.
REQ-008 Port busy, output, 1: high in every state except IDLE.

Function
REQ-009 rx SHALL pass through a 2-flop synchronizer before any use; all "rx" references below mean the synchronized signal (rx_s).
REQ-010 FSM states SHALL be IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-011 IDLE: when rx_s=0, go to START and clear the bit-timer.
REQ-012 START: at timer = CLKS_PER_BIT/2-1 (mid start bit), sample rx_s.
- rx_s=1: false start; return to IDLE with no pulse.
- rx_s=0: go to DATA, bit index 0, timer cleared.
REQ-013 DATA: every CLKS_PER_BIT cycles, sample rx_s into shift-register bit [index], LSB first.
- After index 7 is sampled, go to STOP.
REQ-014 STOP: after CLKS_PER_BIT cycles, sample rx_s.
- rx_s=1: load data_out, pulse valid in the next cycle, go to IDLE.
- rx_s=0: pulse frame_err, leave data_out unchanged, go to WAIT_HIGH.
REQ-015 WAIT_HIGH: stay until rx_s=1, then go to IDLE; a held-low (break) line SHALL produce exactly one frame_err.
REQ-016 valid and frame_err SHALL never be high in the same cycle, and each SHALL be high for exactly one cycle per frame.
REQ-017 Latency: valid SHALL rise at most 9.5*CLKS_PER_BIT+4 cycles after the rx falling edge (2 sync cycles plus 1 register cycle plus margin).
REQ-018 Back-to-back frames: a start bit immediately after a good stop-bit sample SHALL be detected with no lost frame.
REQ-019 The bit-timer SHALL be $clog2(CLKS_PER_BIT) bits wide, reset to 0 on every state change, and never exceed CLKS_PER_BIT-1.
REQ-020 The bit index SHALL be 3 bits; no wrap occurs because the FSM leaves DATA when index=7.

Reset
REQ-021 While rst_n=0: state=IDLE, timer=0, index=0, shift register=0, data_out=8'h00, valid=0, frame_err=0, busy=0, both synchronizer flops=1.
REQ-022 Reset asserted mid-frame SHALL abort the frame with no valid or frame_err pulse.
REQ-023 After reset release, reception SHALL resume from IDLE on the next rx_s low.

Structure
REQ-024 Package uart_pkg SHALL hold the FSM state enum, the CLKS_PER_BIT default and the DATA_BITS=8 constant.
REQ-025 Sub-module sync_2ff (1-bit, reset value parameter) SHALL implement the synchronizer.
REQ-026 The remaining logic (FSM, timer, index, shift register and output registers) SHALL stay in uart_rx.

Verification (CLKS_PER_BIT=16)
REQ-027 Send frame 0xA5 with a good stop bit -> data_out=0xA5, valid high for 1 cycle within 156 cycles of the falling edge, frame_err=0.
REQ-028 Drive a 4-cycle low glitch on an idle line -> no valid, no frame_err, busy returns low within 12 cycles.
REQ-029 Send 0x3C with the stop bit low -> frame_err pulses once, valid=0, data_out keeps its prior value; hold rx low for 64 more cycles -> no further pulses; release rx -> IDLE.
REQ-030 Send back-to-back frames 0x00 then 0xFF with no idle gap -> two valid pulses, carrying 0x00 then 0xFF.
REQ-031 Assert rst_n low during bit 4 of a frame -> all outputs at reset values; next frame 0x5A is received correctly.
REQ-032 Repeat REQ-027 at CLKS_PER_BIT=4 -> same data and pulse behaviour.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver.
// Holds the FSM state encoding and frame geometry.
package uart_pkg;

   localparam int CLKS_PER_BIT_DEF = 16;
   localparam int DATA_BITS        = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_HIGH
   } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
// Both stages reset to RST_VAL so an idle line reads idle.
module sync_2ff #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic s1_q;
   logic s2_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q <= RST_VAL;
         s2_q <= RST_VAL;
      end else begin
         s1_q <= d;
         s2_q <= s1_q;
      end
   end

   assign q = s2_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, framing-error
// detection and break handling.
module uart_rx #(
   parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] data_out,
   output logic       valid,
   output logic       frame_err,
   output logic       busy
);

   import uart_pkg::*;

   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);
   localparam logic [2:0]    LAST   = 3'(DATA_BITS - 1);

   logic rx_s;

   rx_state_e      state_q, state_d;
   logic [TW-1:0]  timer_q, timer_d;
   logic [2:0]     idx_q, idx_d;
   logic [7:0]     shift_q, shift_d;
   logic [7:0]     data_q, data_d;
   logic           valid_q, valid_d;
   logic           ferr_q, ferr_d;
   logic           busy_q, busy_d;

   sync_2ff #(.RST_VAL(1'b1)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (rx),
      .q     (rx_s)
   );

   always_comb begin
      state_d = state_q;
      timer_d = timer_q + 1'b1;
      idx_d   = idx_q;
      shift_d = shift_q;
      data_d  = data_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            timer_d = '0;
            if (!rx_s) state_d = START;
         end
         START: begin
            if (timer_q == T_HALF) begin
               timer_d = '0;
               idx_d   = '0;
               state_d = rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (timer_q == T_FULL) begin
               timer_d        = '0;
               shift_d[idx_q] = rx_s;
               if (idx_q == LAST) state_d = STOP;
               else               idx_d   = idx_q + 3'd1;
            end
         end
         STOP: begin
            if (timer_q == T_FULL) begin
               timer_d = '0;
               if (rx_s) begin
                  data_d  = shift_q;
                  valid_d = 1'b1;
                  state_d = IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = WAIT_HIGH;
               end
            end
         end
         WAIT_HIGH: begin
            // A break holds the line low; only one error per frame.
            timer_d = '0;
            if (rx_s) state_d = IDLE;
         end
         default: begin
            timer_d = '0;
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         timer_q <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
         busy_q  <= busy_d;
      end
   end

   assign data_out  = data_q;
   assign valid     = valid_q;
   assign frame_err = ferr_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CLKS_PER_BIT of 16 and 4.
// Serial frames are driven on negedges, outputs sampled on negedges.
module tb_uart_rx;

   logic       clk;
   logic       rst_n;
   logic       rx16, rx4;
   logic [7:0] data16, data4;
   logic       valid16, valid4;
   logic       ferr16, ferr4;
   logic       busy16, busy4;

   int tests = 0;
   int fails = 0;

   int cyc = 0;
   int fall16 = 0, fall4 = 0;
   int lat16 = 0, lat4 = 0;
   int vcnt16 = 0, vcnt4 = 0;
   int fcnt16 = 0, fcnt4 = 0;
   int both = 0;
   logic [7:0] vq16[$];

   uart_rx #(.CLKS_PER_BIT(16)) dut16 (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx        (rx16),
      .data_out  (data16),
      .valid     (valid16),
      .frame_err (ferr16),
      .busy      (busy16)
   );

   uart_rx #(.CLKS_PER_BIT(4)) dut4 (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx        (rx4),
      .data_out  (data4),
      .valid     (valid4),
      .frame_err (ferr4),
      .busy      (busy4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (valid16) begin
         vcnt16++;
         lat16 = cyc - fall16;
         vq16.push_back(data16);
      end
      if (valid4) begin
         vcnt4++;
         lat4 = cyc - fall4;
      end
      if (ferr16) fcnt16++;
      if (ferr4)  fcnt4++;
      if ((valid16 && ferr16) || (valid4 && ferr4)) both++;
   end

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_rx(input int w, input logic v);
      if (w == 16) rx16 = v;
      else         rx4  = v;
   endtask

   task automatic send_byte(input int w, input logic [7:0] b,
                            input logic stop);
      set_rx(w, 1'b0);
      if (w == 16) fall16 = cyc;
      else         fall4  = cyc;
      wait_n(w);
      for (int i = 0; i < 8; i++) begin
         set_rx(w, b[i]);
         wait_n(w);
      end
      set_rx(w, stop);
      wait_n(w);
   endtask

   int v0, f0, q0;
   logic [7:0] frame;

   initial begin
      rst_n = 1'b0;
      rx16  = 1'b1;
      rx4   = 1'b1;
      wait_n(3);
      check("rst_data", data16, 8'h00);
      check("rst_valid", valid16, 0);
      check("rst_ferr", ferr16, 0);
      check("rst_busy", busy16, 0);
      rst_n = 1'b1;
      wait_n(5);

      // good frame 0xA5
      v0 = vcnt16; f0 = fcnt16;
      send_byte(16, 8'hA5, 1'b1);
      wait_n(4);
      check("a5_vcnt", vcnt16 - v0, 1);
      check("a5_data", data16, 8'hA5);
      check("a5_ferr", fcnt16 - f0, 0);
      check("a5_lat", (lat16 <= 156), 1);
      check("a5_idle", busy16, 0);

      // 4-cycle glitch
      v0 = vcnt16; f0 = fcnt16;
      rx16 = 1'b0;
      wait_n(4);
      rx16 = 1'b1;
      wait_n(2);
      check("gl_busy_hi", busy16, 1);
      wait_n(6);
      check("gl_busy_lo", busy16, 0);
      check("gl_vcnt", vcnt16 - v0, 0);
      check("gl_fcnt", fcnt16 - f0, 0);

      // bad stop bit then held break
      v0 = vcnt16; f0 = fcnt16;
      send_byte(16, 8'h3C, 1'b0);
      wait_n(64);
      check("fe_fcnt", fcnt16 - f0, 1);
      check("fe_vcnt", vcnt16 - v0, 0);
      check("fe_data", data16, 8'hA5);
      check("fe_busy", busy16, 1);
      rx16 = 1'b1;
      wait_n(5);
      check("fe_idle", busy16, 0);
      check("fe_fcnt2", fcnt16 - f0, 1);
      wait_n(10);

      // back-to-back frames
      v0 = vcnt16; q0 = vq16.size();
      send_byte(16, 8'h00, 1'b1);
      send_byte(16, 8'hFF, 1'b1);
      wait_n(4);
      check("bb_vcnt", vcnt16 - v0, 2);
      if (vq16.size() >= q0 + 2) begin
         check("bb_d0", vq16[q0], 8'h00);
         check("bb_d1", vq16[q0 + 1], 8'hFF);
      end else begin
         check("bb_qsize", vq16.size() - q0, 2);
      end
      wait_n(10);

      // reset during bit 4 of 0x5A
      v0 = vcnt16; f0 = fcnt16;
      frame = 8'h5A;
      rx16 = 1'b0;
      wait_n(16);
      for (int i = 0; i < 4; i++) begin
         rx16 = frame[i];
         wait_n(16);
      end
      rx16 = frame[4];
      wait_n(8);
      check("mr_busy_pre", busy16, 1);
      rst_n = 1'b0;
      wait_n(1);
      check("mr_data", data16, 8'h00);
      check("mr_valid", valid16, 0);
      check("mr_ferr", ferr16, 0);
      check("mr_busy", busy16, 0);
      rx16 = 1'b1;
      wait_n(3);
      rst_n = 1'b1;
      wait_n(20);
      check("mr_vcnt", vcnt16 - v0, 0);
      check("mr_fcnt", fcnt16 - f0, 0);
      send_byte(16, 8'h5A, 1'b1);
      wait_n(4);
      check("mr_vcnt2", vcnt16 - v0, 1);
      check("mr_data2", data16, 8'h5A);

      // CLKS_PER_BIT = 4
      v0 = vcnt4; f0 = fcnt4;
      send_byte(4, 8'hA5, 1'b1);
      wait_n(4);
      check("c4_vcnt", vcnt4 - v0, 1);
      check("c4_data", data4, 8'hA5);
      check("c4_ferr", fcnt4 - f0, 0);
      check("c4_lat", (lat4 <= 42), 1);
      check("c4_idle", busy4, 0);

      check("excl", both, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
